hex_key_event_fifo: RTL and testbench

//  Downstream consumer of the hex keypad scanner. Takes its Code/Valid pulses,

---
 rtl/hex_key_event_fifo.sv | 149 ++++++++++++++
 tb/tb_hex_key_event_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hex_key_event_fifo.sv
// Keypad event queue: filters scanner bounce with a per-code hold-off window
// and buffers one event per key press behind a valid/ready output port.
module hex_key_event_fifo #(
    parameter int DEPTH   = 8,
    parameter int HOLD_W  = 16,
    parameter int HOLDOFF = 50000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [3:0]                 key_code,
    input  logic                       key_valid,
    output logic [3:0]                 out_code,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clear_ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } filter_state_t;

    filter_state_t state_q, state_d;
    logic [3:0]        last_code_q, last_code_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]        mem_q [DEPTH];
    logic [3:0]        mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;

    logic accept;
    logic hold_done;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push_ok;
    logic ovf_event;

    assign hold_done = (hold_cnt_q == HOLD_W'(HOLDOFF - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (key_valid) state_d = LOCK;
            LOCK: if (!key_valid && hold_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A repeat of the locked code is bounce; any other code is a new press.
    always_comb begin
        accept = 1'b0;
        case (state_q)
            IDLE: accept = key_valid;
            LOCK: accept = key_valid && (key_code != last_code_q);
            default: accept = 1'b0;
        endcase
    end

    always_comb begin
        last_code_d = last_code_q;
        hold_cnt_d  = hold_cnt_q;
        if (accept) begin
            last_code_d = key_code;
        end
        if (key_valid) begin
            hold_cnt_d = '0;
        end else if (state_q == LOCK) begin
            hold_cnt_d = hold_done ? '0 : hold_cnt_q + HOLD_W'(1);
        end
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign pop        = !fifo_empty && out_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still takes the push.
    assign push_ok    = accept && (!fifo_full || pop);
    assign ovf_event  = accept && fifo_full && !pop;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = key_code;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
        if (ovf_event) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_code_q <= '0;
            hold_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            last_code_q <= last_code_d;
            hold_cnt_q  <= hold_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign out_valid = !fifo_empty;
    assign out_code  = fifo_empty ? 4'h0 : mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_hex_key_event_fifo.sv
// Directed bench for hex_key_event_fifo with DEPTH=4 and HOLDOFF=4;
// expected values are hand-derived from the filter and FIFO behaviour.
module tb_hex_key_event_fifo;

    logic       clock;
    logic       reset;
    logic [3:0] key_code;
    logic       key_valid;
    logic [3:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       overflow;
    logic       clear_ovf;

    int check_count;
    int error_count;

    hex_key_event_fifo #(
        .DEPTH  (4),
        .HOLD_W (16),
        .HOLDOFF(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .key_code (key_code),
        .key_valid(key_valid),
        .out_code (out_code),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count),
        .overflow (overflow),
        .clear_ovf(clear_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] code);
        key_code  = code;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        reset     = 1'b1;
        key_code  = 4'h0;
        key_valid = 1'b0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        tick(2);
        reset = 1'b0;
        tick();

        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_code", 32'(out_code), 32'h0);
        checkOutput("reset_ovf", 32'(overflow), 32'd0);

        // T1 single press
        out_ready = 1'b1;
        applyStimulus(4'hA);
        checkOutput("t1_valid", 32'(out_valid), 32'd1);
        checkOutput("t1_code", 32'(out_code), 32'hA);
        tick();
        checkOutput("t1_count", 32'(count), 32'd0);
        checkOutput("t1_empty_code", 32'(out_code), 32'h0);
        out_ready = 1'b0;
        tick(6);

        // T2 bounce pulses at t, t+2, t+5 then a fresh press later
        applyStimulus(4'h5);
        tick();
        applyStimulus(4'h5);
        tick(2);
        applyStimulus(4'h5);
        checkOutput("t2_one_event", 32'(count), 32'd1);
        tick(6);
        applyStimulus(4'h5);
        checkOutput("t2_second_event", 32'(count), 32'd2);
        checkOutput("t2_head", 32'(out_code), 32'h5);
        out_ready = 1'b1;
        tick();
        checkOutput("t2_second_code", 32'(out_code), 32'h5);
        tick();
        checkOutput("t2_drained", 32'(count), 32'd0);
        out_ready = 1'b0;
        tick(6);

        // T3 fast roll-over
        applyStimulus(4'h3);
        applyStimulus(4'hC);
        checkOutput("t3_count", 32'(count), 32'd2);
        checkOutput("t3_first", 32'(out_code), 32'h3);
        out_ready = 1'b1;
        tick();
        checkOutput("t3_second", 32'(out_code), 32'hC);
        tick();
        checkOutput("t3_drained", 32'(count), 32'd0);
        out_ready = 1'b0;
        tick(6);

        // T4 fill and overflow
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(4'(i));
            tick(6);
        end
        checkOutput("t4_count", 32'(count), 32'd4);
        checkOutput("t4_ovf", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("t4_drain%0d", i), 32'(out_code), 32'(i));
            tick();
        end
        out_ready = 1'b0;
        checkOutput("t4_drained", 32'(count), 32'd0);
        checkOutput("t4_ovf_sticky", 32'(overflow), 32'd1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        checkOutput("t4_ovf_cleared", 32'(overflow), 32'd0);

        // T5 full with simultaneous pop and push
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(4'(i));
            tick(6);
        end
        checkOutput("t5_full", 32'(count), 32'd4);
        out_ready = 1'b1;
        applyStimulus(4'h9);
        checkOutput("t5_no_ovf", 32'(overflow), 32'd0);
        checkOutput("t5_count", 32'(count), 32'd4);
        checkOutput("t5_drain2", 32'(out_code), 32'h2);
        tick();
        checkOutput("t5_drain3", 32'(out_code), 32'h3);
        tick();
        checkOutput("t5_drain4", 32'(out_code), 32'h4);
        tick();
        checkOutput("t5_drain9", 32'(out_code), 32'h9);
        tick();
        checkOutput("t5_drained", 32'(count), 32'd0);
        out_ready = 1'b0;
        tick(6);

        // T6 reset with entries queued and the filter locked on code 8
        applyStimulus(4'h7);
        tick(6);
        applyStimulus(4'h8);
        checkOutput("t6_queued", 32'(count), 32'd2);
        reset = 1'b1;
        #3;
        checkOutput("t6_count", 32'(count), 32'd0);
        checkOutput("t6_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_ovf", 32'(overflow), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        applyStimulus(4'h8);
        checkOutput("t6_reaccept", 32'(count), 32'd1);
        checkOutput("t6_code", 32'(out_code), 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
